// File: rtl/uart_pkg.sv
// Shared definitions for the UART baud configuration slice: rate codes,
// controller states and default pulse thresholds for a 50 MHz clock.
// Optional feature macro: AUTOBAUD_VERIFY_EN (measure all five low pulses
// of the 0x55 sync character instead of the start bit alone).
package uart_pkg;

  typedef logic [1:0] rate_t;

  localparam rate_t RATE_2400  = 2'd0;
  localparam rate_t RATE_4800  = 2'd1;
  localparam rate_t RATE_9600  = 2'd2;
  localparam rate_t RATE_19200 = 2'd3;

  typedef enum logic [2:0] {
    IDLE,
    ARM,
    WAIT_FALL,
    MEAS_LOW,
    MEAS_HIGH,
    APPLY,
    LOCKED,
    ERROR
  } state_t;

  // Defaults at 50 MHz; one bit at 2400 baud is 20833 cycles.
  localparam int unsigned DEF_CNT_W      = 16;
  localparam int unsigned DEF_IDLE_CYC   = 1024;
  localparam int unsigned DEF_GLITCH_MIN = 1302;   // half a 19200 bit
  localparam int unsigned DEF_LOW_MAX    = 31250;  // 1.5 bits at 2400
  localparam int unsigned DEF_TH_01      = 15625;  // 2400 / 4800 boundary
  localparam int unsigned DEF_TH_12      = 7812;   // 4800 / 9600 boundary
  localparam int unsigned DEF_TH_23      = 3906;   // 9600 / 19200 boundary
  localparam int unsigned DEF_APPLY_CYC  = 2;

  // Low pulses in 0x55: the start bit, then data bits 1, 3, 5 and 7.
`ifdef AUTOBAUD_VERIFY_EN
  localparam int unsigned PULSE_CNT = 5;
`else
  localparam int unsigned PULSE_CNT = 1;
`endif

endpackage

// File: rtl/uart_baud_ctrl_if.sv
// Control/status bundle between the UART top level (CPU side) and the
// baud configuration controller.
interface uart_baud_ctrl_if;
  import uart_pkg::*;

  logic  start;
  logic  abort;
  logic  cfg_load;
  rate_t manual_rate;
  rate_t baud_rate;
  logic  baud_gen_rst_n;
  logic  busy;
  logic  locked;
  logic  err;

  modport master (
    output start, abort, cfg_load, manual_rate,
    input  baud_rate, baud_gen_rst_n, busy, locked, err
  );

  modport slave (
    input  start, abort, cfg_load, manual_rate,
    output baud_rate, baud_gen_rst_n, busy, locked, err
  );

endinterface

// File: rtl/uart_pulse_classifier.sv
// Combinational pulse-length classifier: maps a measured low-pulse length in
// clock cycles to a rate code and flags too-short and too-long pulses.
// Shared with the RX framing checker.
module uart_pulse_classifier
  import uart_pkg::*;
#(
  parameter int unsigned CNT_W      = DEF_CNT_W,
  parameter int unsigned GLITCH_MIN = DEF_GLITCH_MIN,
  parameter int unsigned LOW_MAX    = DEF_LOW_MAX,
  parameter int unsigned TH_01      = DEF_TH_01,
  parameter int unsigned TH_12      = DEF_TH_12,
  parameter int unsigned TH_23      = DEF_TH_23
) (
  input  logic [CNT_W-1:0] cnt,
  output rate_t            code,
  output logic             glitch,
  output logic             overflow
);

  localparam logic [CNT_W-1:0] GLITCH_V = CNT_W'(GLITCH_MIN);
  localparam logic [CNT_W-1:0] LOW_MAX_V = CNT_W'(LOW_MAX);
  localparam logic [CNT_W-1:0] TH_01_V  = CNT_W'(TH_01);
  localparam logic [CNT_W-1:0] TH_12_V  = CNT_W'(TH_12);
  localparam logic [CNT_W-1:0] TH_23_V  = CNT_W'(TH_23);

  // Longer pulses mean slower rates; anything below TH_23 is the fastest band.
  always_comb begin
    // NOTE: default assignment first so every path drives code and no latch is inferred.
    code = RATE_19200;
    if (cnt >= TH_01_V) begin
      code = RATE_2400;
    end else if (cnt >= TH_12_V) begin
      code = RATE_4800;
    end else if (cnt >= TH_23_V) begin
      code = RATE_9600;
    end
  end

  assign glitch   = (cnt < GLITCH_V);
  assign overflow = (cnt >= LOW_MAX_V);

endmodule

// File: rtl/uart_baud_ctrl.sv
// UART baud configuration controller. Auto-detects the line rate from a 0x55
// sync character on rx (or takes a manual rate load), drives the baud
// generator's rate code and pulses its active-low reset so the new divider
// starts cleanly.
// Optional feature macro: AUTOBAUD_VERIFY_EN (all five low pulses of 0x55
// must classify to the same code before the rate is applied).
module uart_baud_ctrl
  import uart_pkg::*;
#(
  parameter int unsigned CNT_W      = DEF_CNT_W,
  parameter int unsigned IDLE_CYC   = DEF_IDLE_CYC,
  parameter int unsigned GLITCH_MIN = DEF_GLITCH_MIN,
  parameter int unsigned LOW_MAX    = DEF_LOW_MAX,
  parameter int unsigned TH_01      = DEF_TH_01,
  parameter int unsigned TH_12      = DEF_TH_12,
  parameter int unsigned TH_23      = DEF_TH_23,
  parameter int unsigned APPLY_CYC  = DEF_APPLY_CYC
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             rx,
  uart_baud_ctrl_if.slave  bus
);

  localparam int unsigned     PW         = (APPLY_CYC > 1) ? $clog2(APPLY_CYC) : 1;
  localparam logic [PW-1:0]   PULSE_LOAD = PW'(APPLY_CYC - 1);
  localparam logic [CNT_W-1:0] ARM_LAST  = CNT_W'(IDLE_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [2:0]      PULSE_LAST = 3'(PULSE_CNT - 1);

  logic             rx_meta;
  logic             rx_s;
  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_inc;
  rate_t            cand;
  logic [2:0]       pulse_idx;
  logic [PW-1:0]    pulse_cnt;

  rate_t baud_rate_q;
  logic  baud_gen_rst_n_q;
  logic  busy_q;
  logic  locked_q;
  logic  err_q;

  rate_t code;
  logic  glitch;
  logic  overflow;
  logic  meas_fail;

  uart_pulse_classifier #(
    .CNT_W      (CNT_W),
    .GLITCH_MIN (GLITCH_MIN),
    .LOW_MAX    (LOW_MAX),
    .TH_01      (TH_01),
    .TH_12      (TH_12),
    .TH_23      (TH_23)
  ) classifier (
    .cnt      (cnt),
    .code     (code),
    .glitch   (glitch),
    .overflow (overflow)
  );

  // The measurement counter holds at all-ones rather than wrapping.
  assign cnt_inc = (&cnt) ? cnt : cnt + 1'b1;

  // Any phase that ran too long, a low pulse that ended too early, or a later
  // pulse that disagrees with the first one aborts the measurement.
  assign meas_fail = overflow ||
                     ((state == MEAS_LOW) && rx_s &&
                      (glitch || ((pulse_idx != '0) && (code != cand))));

  // Two-flop synchroniser for the asynchronous serial line.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      // NOTE: the synchroniser resets to the idle-high line level so leaving reset never looks like a falling edge.
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  // Control FSM with registered outputs, plus the generator reset-pulse timer.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state            <= IDLE;
      cnt              <= '0;
      cand             <= RATE_9600;
      pulse_idx        <= '0;
      pulse_cnt        <= '0;
      baud_rate_q      <= RATE_9600;
      baud_gen_rst_n_q <= 1'b0;
      busy_q           <= 1'b0;
      locked_q         <= 1'b0;
      err_q            <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments throughout; a later assignment in this block overrides the earlier default.
      // The pulse timer runs independently of the state so an abort during
      // APPLY still releases the generator after APPLY_CYC cycles.
      if (!baud_gen_rst_n_q) begin
        if (pulse_cnt == '0) begin
          baud_gen_rst_n_q <= 1'b1;
        end else begin
          pulse_cnt <= pulse_cnt - 1'b1;
        end
      end

      if (bus.abort) begin
        state     <= IDLE;
        busy_q    <= 1'b0;
        err_q     <= 1'b0;
        cnt       <= '0;
        pulse_idx <= '0;
        if (state != LOCKED) begin
          locked_q <= 1'b0;
        end
      end else begin
        case (state)
          IDLE, LOCKED, ERROR: begin
            if (bus.start) begin
              state     <= ARM;
              busy_q    <= 1'b1;
              locked_q  <= 1'b0;
              err_q     <= 1'b0;
              cnt       <= '0;
              pulse_idx <= '0;
            end else if (bus.cfg_load) begin
              cand             <= bus.manual_rate;
              baud_rate_q      <= bus.manual_rate;
              baud_gen_rst_n_q <= 1'b0;
              pulse_cnt        <= PULSE_LOAD;
              locked_q         <= 1'b0;
              err_q            <= 1'b0;
              state            <= APPLY;
            end
          end

          ARM: begin
            if (!rx_s) begin
              cnt <= '0;
            end else if (cnt >= ARM_LAST) begin
              cnt   <= '0;
              state <= WAIT_FALL;
            end else begin
              cnt <= cnt_inc;
            end
          end

          WAIT_FALL: begin
            if (!rx_s) begin
              cnt   <= CNT_ONE;
              state <= MEAS_LOW;
            end
          end

          MEAS_LOW, MEAS_HIGH: begin
            if (meas_fail) begin
              state    <= ERROR;
              err_q    <= 1'b1;
              busy_q   <= 1'b0;
              locked_q <= 1'b0;
            end else if (state == MEAS_LOW) begin
              if (!rx_s) begin
                cnt <= cnt_inc;
              end else begin
                if (pulse_idx == '0) begin
                  cand <= code;
                end
                if (pulse_idx == PULSE_LAST) begin
                  baud_rate_q      <= (pulse_idx == '0) ? code : cand;
                  baud_gen_rst_n_q <= 1'b0;
                  pulse_cnt        <= PULSE_LOAD;
                  cnt              <= '0;
                  state            <= APPLY;
                end else begin
                  pulse_idx <= pulse_idx + 1'b1;
                  cnt       <= CNT_ONE;
                  state     <= MEAS_HIGH;
                end
              end
            end else begin
              if (rx_s) begin
                cnt <= cnt_inc;
              end else begin
                cnt   <= CNT_ONE;
                state <= MEAS_LOW;
              end
            end
          end

          APPLY: begin
            if (pulse_cnt == '0) begin
              locked_q <= 1'b1;
              busy_q   <= 1'b0;
              state    <= LOCKED;
            end
          end

          default: state <= IDLE;
        endcase
      end
    end
  end

  assign bus.baud_rate      = baud_rate_q;
  assign bus.baud_gen_rst_n = baud_gen_rst_n_q;
  assign bus.busy           = busy_q;
  assign bus.locked         = locked_q;
  assign bus.err            = err_q;

endmodule

// File: tb/tb_uart_baud_ctrl.sv
// Directed bench for uart_baud_ctrl. Generator reset pulses are checked by a
// scoreboard: each expected rate change is queued when its stimulus is
// driven and popped when baud_gen_rst_n rises. Timing parameters are the
// 50 MHz defaults divided by 16 so every bit period still falls in the same
// code band while the run stays short.
module tb_uart_baud_ctrl;
  import uart_pkg::*;

  localparam int unsigned CNT_W      = 16;
  localparam int unsigned IDLE_CYC   = 64;
  localparam int unsigned GLITCH_MIN = 81;
  localparam int unsigned LOW_MAX    = 1953;
  localparam int unsigned TH_01      = 977;
  localparam int unsigned TH_12      = 488;
  localparam int unsigned TH_23      = 244;
  localparam int unsigned APPLY_CYC  = 2;

  localparam int BIT_2400  = 1302;
  localparam int BIT_4800  = 651;
  localparam int BIT_9600  = 326;
  localparam int BIT_19200 = 163;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  logic rx    = 1'b1;

  uart_baud_ctrl_if bus();

  uart_baud_ctrl #(
    .CNT_W      (CNT_W),
    .IDLE_CYC   (IDLE_CYC),
    .GLITCH_MIN (GLITCH_MIN),
    .LOW_MAX    (LOW_MAX),
    .TH_01      (TH_01),
    .TH_12      (TH_12),
    .TH_23      (TH_23),
    .APPLY_CYC  (APPLY_CYC)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .rx    (rx),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    rate_t rate;
    int    len;
  } apply_t;

  apply_t exp_q[$];
  apply_t mon_e;
  int     total = 0;
  int     bad   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard side: measure every generator reset pulse outside global reset.
  int low_run     = 0;
  bit after_reset = 1'b1;
  always @(negedge clk) begin
    if (!reset) begin
      low_run     = 0;
      after_reset = 1'b1;
    end else if (bus.baud_gen_rst_n !== 1'b1) begin
      low_run++;
    end else begin
      if (low_run != 0 && !after_reset) begin
        check("apply_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          mon_e = exp_q.pop_front();
          check("apply_rate", bus.baud_rate, mon_e.rate);
          check("apply_len", low_run, mon_e.len);
        end
      end
      low_run     = 0;
      after_reset = 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  task automatic pulse(input bit s, input bit a, input bit c);
    bus.start    = s;
    bus.abort    = a;
    bus.cfg_load = c;
    tick();
    bus.start    = 1'b0;
    bus.abort    = 1'b0;
    bus.cfg_load = 1'b0;
  endtask

  task automatic send_tail(input int len);
    logic [7:0] d;
    d = 8'h55;
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      ticks(len);
    end
    rx = 1'b1;
    ticks(len);
  endtask

  task automatic send_frame(input int start_len, input int bit_len);
    rx = 1'b0;
    ticks(start_len);
    send_tail(bit_len);
  endtask

  task automatic arm(input string tag);
    pulse(1'b1, 1'b0, 1'b0);
    check({tag, "_busy_on_start"}, bus.busy, 1);
    check({tag, "_err_clr_start"}, bus.err, 0);
    ticks(3 * IDLE_CYC);
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n;
    n = 0;
    while (!(bus.locked === 1'b1 || bus.err === 1'b1) && n < budget) begin
      tick();
      n++;
    end
    check({tag, "_timeout"}, n < budget, 1);
  endtask

  task automatic expect_out(input string tag, input bit busy, input bit lk,
                            input bit er, input rate_t rate);
    check({tag, "_busy"}, bus.busy, busy);
    check({tag, "_locked"}, bus.locked, lk);
    check({tag, "_err"}, bus.err, er);
    check({tag, "_rate"}, bus.baud_rate, rate);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_rate"}, bus.baud_rate, RATE_9600);
    check({tag, "_gen_rst_n"}, bus.baud_gen_rst_n, 0);
    check({tag, "_busy"}, bus.busy, 0);
    check({tag, "_locked"}, bus.locked, 0);
    check({tag, "_err"}, bus.err, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.start       = 1'b0;
    bus.abort       = 1'b0;
    bus.cfg_load    = 1'b0;
    bus.manual_rate = RATE_2400;

    // Reset state and generator release on the first clock after reset.
    ticks(3);
    check_reset_values("rst");
    reset = 1'b1;
    tick();
    check("rst_release_gen", bus.baud_gen_rst_n, 1);

    // Auto-detect at 9600.
    arm("t9600");
    exp_q.push_back('{RATE_9600, APPLY_CYC});
    send_frame(BIT_9600, BIT_9600);
    wait_done("t9600", 100);
    expect_out("t9600", 1'b0, 1'b1, 1'b0, RATE_9600);

    // Short low glitch after arming: error, rate untouched.
    arm("glitch");
    rx = 1'b0;
    ticks(31);
    rx = 1'b1;
    wait_done("glitch", 100);
    expect_out("glitch", 1'b0, 1'b0, 1'b1, RATE_9600);

    // 2400 and 19200, starting from ERROR.
    arm("t2400");
    exp_q.push_back('{RATE_2400, APPLY_CYC});
    send_frame(BIT_2400, BIT_2400);
    wait_done("t2400", 100);
    expect_out("t2400", 1'b0, 1'b1, 1'b0, RATE_2400);

    arm("t19200");
    exp_q.push_back('{RATE_19200, APPLY_CYC});
    send_frame(BIT_19200, BIT_19200);
    wait_done("t19200", 100);
    expect_out("t19200", 1'b0, 1'b1, 1'b0, RATE_19200);

    // Classification boundary at TH_23.
    arm("th23_at");
    exp_q.push_back('{RATE_9600, APPLY_CYC});
    send_frame(TH_23, TH_23);
    wait_done("th23_at", 100);
    expect_out("th23_at", 1'b0, 1'b1, 1'b0, RATE_9600);

    arm("th23_below");
    exp_q.push_back('{RATE_19200, APPLY_CYC});
    send_frame(TH_23 - 1, TH_23 - 1);
    wait_done("th23_below", 100);
    expect_out("th23_below", 1'b0, 1'b1, 1'b0, RATE_19200);

    // One cycle short of the glitch limit is still a glitch.
    arm("glitch_edge");
    rx = 1'b0;
    ticks(GLITCH_MIN - 1);
    rx = 1'b1;
    wait_done("glitch_edge", 100);
    expect_out("glitch_edge", 1'b0, 1'b0, 1'b1, RATE_19200);

    // Low phase running past LOW_MAX times out.
    arm("overflow");
    rx = 1'b0;
    ticks(LOW_MAX + 50);
    wait_done("overflow", 100);
    expect_out("overflow", 1'b0, 1'b0, 1'b1, RATE_19200);
    rx = 1'b1;
    ticks(10);

    // Start bit at 9600, data bits at 4800.
    arm("mixed");
`ifndef AUTOBAUD_VERIFY_EN
    exp_q.push_back('{RATE_9600, APPLY_CYC});
`endif
    send_frame(BIT_9600, BIT_4800);
    wait_done("mixed", 100);
`ifdef AUTOBAUD_VERIFY_EN
    expect_out("mixed", 1'b0, 1'b0, 1'b1, RATE_19200);
`else
    expect_out("mixed", 1'b0, 1'b1, 1'b0, RATE_9600);
`endif

    // Manual load of 4800; busy stays low throughout.
    bus.manual_rate = RATE_4800;
    exp_q.push_back('{RATE_4800, APPLY_CYC});
    pulse(1'b0, 1'b0, 1'b1);
    check("manual_busy", bus.busy, 0);
    ticks(5);
    expect_out("manual", 1'b0, 1'b1, 1'b0, RATE_4800);

    // cfg_load while measuring the start bit is ignored.
    arm("cfg_ign");
    exp_q.push_back('{RATE_9600, APPLY_CYC});
    rx = 1'b0;
    ticks(150);
    bus.manual_rate = RATE_2400;
    pulse(1'b0, 1'b0, 1'b1);
    check("cfg_ign_busy", bus.busy, 1);
    check("cfg_ign_rate", bus.baud_rate, RATE_4800);
    ticks(BIT_9600 - 151);
    send_tail(BIT_9600);
    wait_done("cfg_ign", 100);
    expect_out("cfg_ign", 1'b0, 1'b1, 1'b0, RATE_9600);

    // abort beats start in the same cycle during MEAS_LOW.
    arm("abort");
    rx = 1'b0;
    ticks(50);
    pulse(1'b1, 1'b1, 1'b0);
    check("abort_busy", bus.busy, 0);
    check("abort_err", bus.err, 0);
    check("abort_locked", bus.locked, 0);
    rx = 1'b1;
    ticks(50);
    expect_out("abort_idle", 1'b0, 1'b0, 1'b0, RATE_9600);

    // Manual load from IDLE, then abort in LOCKED keeps locked.
    bus.manual_rate = RATE_2400;
    exp_q.push_back('{RATE_2400, APPLY_CYC});
    pulse(1'b0, 1'b0, 1'b1);
    ticks(5);
    expect_out("manual_idle", 1'b0, 1'b1, 1'b0, RATE_2400);
    pulse(1'b0, 1'b1, 1'b0);
    expect_out("abort_locked", 1'b0, 1'b1, 1'b0, RATE_2400);

    // Asynchronous reset in the middle of a measurement.
    arm("rst_mid");
    rx = 1'b0;
    ticks(100);
    reset = 1'b0;
    #1;
    check_reset_values("rst_mid");
    rx = 1'b1;
    ticks(3);
    reset = 1'b1;
    tick();
    check("rst_mid_release_gen", bus.baud_gen_rst_n, 1);
    expect_out("rst_mid_after", 1'b0, 1'b0, 1'b0, RATE_9600);

    ticks(10);
    check("sb_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
